// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and helpers for the GPR writeback arbiter.
// Source ids, address map and round-robin pointer math.
package regfile_wr_arbiter_pkg;

  localparam int GPR_WIDTH      = 8;
  localparam int GPR_DEPTH      = 8;
  localparam int REG_ADDR_W     = 4;
  localparam int PERIPH_SEL_BIT = 3;
  localparam int NUM_WB_SRC     = 3;

  typedef enum logic [1:0] {
    WB_SRC_ALU    = 2'd0,
    WB_SRC_LOAD   = 2'd1,
    WB_SRC_PERIPH = 2'd2
  } wb_src_e;

  // Next round-robin start: one past the winner, wrapping.
  function automatic int next_ptr(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// Combinational round-robin picker.
// Valid vector + start pointer -> one-hot grant and index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan from ptr, wrapping, and take the first valid slot.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// GPR write-port arbiter: round-robin grant, registered issue,
// pending-write scoreboard and peripheral-address drop.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int GPR_WIDTH = regfile_wr_arbiter_pkg::GPR_WIDTH,
  parameter int GPR_DEPTH = regfile_wr_arbiter_pkg::GPR_DEPTH,
  parameter int ADDR_W    = REG_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*GPR_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           pend_set,
  input  logic [ADDR_W-1:0]              pend_addr,
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [GPR_WIDTH-1:0]           wr_data,
  output logic [GPR_DEPTH-1:0]           busy,
  output logic                           drop
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int GIDX_W = $clog2(GPR_DEPTH);

  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     g_idx;
  logic                 g_any;
  logic                 xfer;
  logic                 periph;
  logic [ADDR_W-1:0]    sel_addr;
  logic [GPR_WIDTH-1:0] sel_data;
  logic [GPR_DEPTH-1:0] busy_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  assign req_ready = rst_n ? grant : '0;
  assign xfer      = g_any & rst_n;
  assign periph    = sel_addr[PERIPH_SEL_BIT];

  // Route the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*GPR_WIDTH +: GPR_WIDTH];
      end
    end
  end

  // Advance the start pointer past each winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= IDX_W'(next_ptr(int'(g_idx), NUM_REQ));
    end
  end

  // Issue register: GPR writes forward, peripheral ones drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      drop    <= 1'b0;
    end else if (xfer && !periph) begin
      wr_en   <= 1'b1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      drop    <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      drop    <= xfer;
    end
  end

  // Retire on the issued write, then mark new producer (wins).
  always_comb begin
    busy_nxt = busy;
    if (wr_en) begin
      busy_nxt[wr_addr[GIDX_W-1:0]] = 1'b0;
    end
    if (pend_set && !pend_addr[PERIPH_SEL_BIT]) begin
      busy_nxt[pend_addr[GIDX_W-1:0]] = 1'b1;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule
